// File: rtl/counter_pkg.sv
// Shared types and defaults for the counter load sequencer.
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    function automatic int term_default(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester not served last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] win
);

    always_comb begin
        win = 2'b00;
        unique case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = last ? 2'b01 : 2'b10;
            default: win = 2'b00;
        endcase
    end

endmodule

// File: rtl/counter_load_sequencer.sv
// Arbitrates two requesters, loads an external counter and runs it to TERM
// under watchdog supervision.
module counter_load_sequencer
    import counter_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TERM  = WIDTH'(term_default(WIDTH)),
    parameter int               WDOG  = 2**WIDTH + 2
) (
    input  logic             clk_50,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] load_val0,
    input  logic [WIDTH-1:0] load_val1,
    input  logic [WIDTH-1:0] count_q,
    output logic             load_1,
    output logic [WIDTH-1:0] count_in,
    output logic             count_en,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic             wd_err,
    output logic             busy
);

    localparam int WDW = $clog2(WDOG + 1);

    state_t         state;
    state_t         state_n;
    logic           win_idx;
    logic           last;
    logic [WDW-1:0] wd;
    logic [1:0]     arb_win;
    logic [1:0]     win_oh;
    logic           win_req;
    logic           at_term;
    logic           wd_hit;
    logic           served;
    logic           wd_abort;

    rr_arb2 u_arb (
        .req  (req),
        .last (last),
        .win  (arb_win)
    );

    assign win_oh  = win_idx ? 2'b10 : 2'b01;
    assign win_req = req[win_idx];
    assign at_term = (count_q == TERM);
    assign wd_hit  = (wd == WDW'(WDOG - 1));

    always_comb begin
        state_n  = state;
        served   = 1'b0;
        wd_abort = 1'b0;
        unique case (state)
            IDLE: begin
                if (|req) state_n = LOAD;
            end
            LOAD: begin
                state_n = win_req ? RUN : IDLE;
                served  = !win_req;
            end
            RUN: begin
                if (!win_req) begin
                    state_n = IDLE;
                    served  = 1'b1;
                end else if (at_term) begin
                    state_n = DONE;
                end else if (wd_hit) begin
                    state_n  = IDLE;
                    served   = 1'b1;
                    wd_abort = 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
                served  = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        load_1   = (state != LOAD);
        count_en = (state == RUN) && win_req && !at_term;
        gnt      = busy ? win_oh : 2'b00;
        done     = (state == DONE) ? win_oh : 2'b00;
    end

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            win_idx  <= 1'b0;
            last     <= 1'b1;
            count_in <= '0;
            wd       <= '0;
            wd_err   <= 1'b0;
        end else begin
            state  <= state_n;
            wd_err <= wd_abort;
            if (state == IDLE && |req) begin
                win_idx  <= arb_win[1];
                count_in <= arb_win[1] ? load_val1 : load_val0;
            end
            // Watchdog counts RUN cycles of the current run only
            if (state_n == LOAD) wd <= '0;
            else if (state == RUN) wd <= wd + 1'b1;
            if (served) last <= win_idx;
        end
    end

endmodule

// File: doc/counter_load_sequencer.md
COUNTER_LOAD_SEQUENCER -- requirements
Module: counter_load_sequencer

Interface
REQ-001 Parameter WIDTH, default 4: width of the counter, load values and count feedback.
REQ-002 Parameter TERM, default 4'hF (all ones of WIDTH): terminal count that ends a run.
REQ-003 Parameter WDOG, default 2**WIDTH+2: maximum cycles allowed in RUN before abort.
REQ-004 Port clk_50, input, 1: the single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port req, input, 2: per-requester run request, level, held until done or abort.
REQ-007 Port load_val0 / load_val1, input, WIDTH each: start value for requester 0 / 1.
REQ-008 Port count_q, input, WIDTH: present value of the controlled loadable counter.
REQ-009 Port load_1, output, 1: active-low synchronous load strobe to the counter.
REQ-010 Port count_in, output, WIDTH: load value presented to the counter.
REQ-011 Port count_en, output, 1: counter increment enable.
REQ-012 Port gnt, output, 2: one-hot grant, held LOAD through DONE.
REQ-013 Port done, output, 2: one-cycle pulse to the granted requester on reaching TERM.
REQ-014 Port wd_err, output, 1: one-cycle pulse on watchdog abort.
REQ-015 Port busy, output, 1: high whenever state is not IDLE.

Function
REQ-016 FSM states IDLE, LOAD, RUN, DONE; state register updates on rising clk_50.
REQ-017 IDLE: with req nonzero, latch winner index and its load_val into count_in register, go to LOAD next edge; else stay.
REQ-018 Arbitration round-robin: with both req high, requester other than last-served wins; single request wins immediately.
REQ-019 LOAD lasts exactly one cycle: load_1=0, count_en=0; next state RUN.
REQ-020 RUN: count_en = 1 only while count_q != TERM; when count_q == TERM go to DONE next edge (counter never wraps).
REQ-021 Load value equal to TERM: RUN lasts one cycle, count_en stays 0, then DONE.
REQ-022 DONE lasts one cycle: done[winner]=1, count_en=0, last-served pointer updated; next state IDLE.
REQ-023 Winner's req low during LOAD or RUN: abort to IDLE next edge, no done pulse, pointer still updated.
REQ-024 Watchdog counter clears on LOAD entry, increments each RUN cycle; reaching WDOG in RUN: wd_err pulse, go IDLE, no done.
REQ-025 Latency: req sampled high in IDLE at edge n -> load_1 low in cycle n+1 -> count_en high from cycle n+2.
REQ-026 count_in stable from LOAD through DONE; load_val changes after IDLE sampling are ignored.
REQ-027 Non-winner req changes during a run have no effect until IDLE.
REQ-028 gnt and done never both assert for two requesters; gnt zero in IDLE.

Reset
REQ-029 reset high forces IDLE immediately, regardless of clock, including mid-run.
REQ-030 Reset values: load_1=1, count_in=0, count_en=0, gnt=0, done=0, wd_err=0, busy=0, watchdog=0, pointer favours requester 0.
REQ-031 First arbitration after reset release grants requester 0 on simultaneous requests.

Structure
REQ-032 State enum and TERM default live in shared package counter_pkg; WIDTH passed as parameter.
REQ-033 Round-robin selection is sub-module rr_arb2 (req[1:0], pointer -> one-hot winner); remaining logic is flat.

Verification
REQ-034 Scenario: req=01, load_val0=4'hC, behavioural counter -> load_1 low one cycle, count_en 3 cycles, count_q stops at F, done=01 one cycle.
REQ-035 Scenario: req=11 from reset -> gnt=01 first; after done, gnt=10 without idle gap beyond one IDLE cycle.
REQ-036 Scenario: load_val1=4'hF, req=10 -> count_en never high, done=10 three cycles after request.
REQ-037 Scenario: counter stuck at 0 -> wd_err pulse after WDOG=18 RUN cycles, busy drops, no done.
REQ-038 Scenario: req drop mid-RUN at count_q=6 -> IDLE next edge, count_en 0, no done; reset mid-RUN -> all outputs at reset values asynchronously.
